// File: rtl/stage_if_prefetch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// stage_if_prefetch : IF stage with a DEPTH-entry {pc, instr} prefetch queue
// Revision: 1.0
// ---------------------------------------------------------------------------
module stage_if_prefetch #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [11:0] Instruction_addressbus,
  input  logic [15:0] Instruction_databus,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [15:0] out_pc,
  output logic [15:0] out_instr,
  output logic [3:0]  occupancy
);

  localparam int         PW      = $clog2(DEPTH);
  localparam logic [3:0] c_DEPTH = 4'(DEPTH);

  logic [15:0]   pc_mem_q    [DEPTH];
  logic [15:0]   instr_mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [3:0]    count_q, count_d;
  logic [15:0]   fetch_pc_q, fetch_pc_d;
  logic          do_pop, do_push;

  always_comb begin
    do_pop     = (count_q != 4'd0) && out_ready;
    // A pop frees a slot in the same cycle, so a full queue still streams.
    do_push    = !redirect && ((count_q < c_DEPTH) || do_pop);
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    fetch_pc_d = fetch_pc_q;
    if (redirect) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = 4'd0;
      fetch_pc_d = redirect_pc;
    end else begin
      if (do_push) begin
        wr_ptr_d   = wr_ptr_q + PW'(1);
        fetch_pc_d = fetch_pc_q + 16'd1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + {3'b000, do_push} - {3'b000, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= 4'd0;
      fetch_pc_q <= RESET_PC;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      fetch_pc_q <= fetch_pc_d;
      if (do_push) begin
        pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
        instr_mem_q[wr_ptr_q] <= Instruction_databus;
      end
    end
  end

  assign Instruction_addressbus = fetch_pc_q[11:0];
  assign occupancy              = count_q;
  assign out_valid              = (count_q != 4'd0);
  assign out_pc                 = out_valid ? pc_mem_q[rd_ptr_q]    : 16'h0000;
  assign out_instr              = out_valid ? instr_mem_q[rd_ptr_q] : 16'h0000;

endmodule
`default_nettype wire

// File: tb/tb_stage_if_prefetch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_stage_if_prefetch : directed and random checks against a queue model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_stage_if_prefetch;

  localparam int          DEPTH    = 4;
  localparam logic [15:0] RESET_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] addr;
  logic [15:0] instr_bus;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        out_ready;
  logic        out_valid;
  logic [15:0] out_pc;
  logic [15:0] out_instr;
  logic [3:0]  occupancy;
  bit          mode_id;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] ins;
  } ent_t;

  ent_t        q[$];
  logic [15:0] mfpc;

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_f(input logic [11:0] a, input bit id);
    if (id) return {4'h0, a};
    return {a[7:4] ^ 4'h9, a ^ 12'h5A3};
  endfunction

  assign instr_bus = mem_f(addr, mode_id);

  stage_if_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .Instruction_addressbus (addr),
    .Instruction_databus    (instr_bus),
    .redirect               (redirect),
    .redirect_pc            (redirect_pc),
    .out_ready              (out_ready),
    .out_valid              (out_valid),
    .out_pc                 (out_pc),
    .out_instr              (out_instr),
    .occupancy              (occupancy)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic [15:0] epc, eins;
    epc  = (q.size() != 0) ? q[0].pc  : 16'h0000;
    eins = (q.size() != 0) ? q[0].ins : 16'h0000;
    chk("valid", 16'(out_valid), 16'(q.size() != 0));
    chk("out_pc", out_pc, epc);
    chk("out_instr", out_instr, eins);
    chk("occupancy", 16'(occupancy), 16'(q.size()));
    chk("addrbus", 16'(addr), {4'h0, mfpc[11:0]});
  endtask

  // Drive one cycle of inputs, advance the model across the edge, check at negedge.
  task automatic step(input bit r, input bit rd, input logic [15:0] rpc, input bit rdy);
    bit pop, push;
    rst = r; redirect = rd; redirect_pc = rpc; out_ready = rdy;
    @(posedge clk);
    if (r) begin
      q.delete();
      mfpc = RESET_PC;
    end else if (rd) begin
      q.delete();
      mfpc = rpc;
    end else begin
      pop  = (q.size() != 0) && rdy;
      push = (q.size() < DEPTH) || pop;
      if (pop) void'(q.pop_front());
      if (push) begin
        q.push_back('{pc: mfpc, ins: mem_f(mfpc[11:0], mode_id)});
        mfpc = mfpc + 16'd1;
      end
    end
    @(negedge clk);
    check_model();
  endtask

  initial begin
    logic [15:0] wrap_pcs [4];
    wrap_pcs = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    mode_id = 1'b1;
    rst = 1'b1; redirect = 1'b0; redirect_pc = 16'h0000; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    q.delete();
    mfpc = RESET_PC;
    @(negedge clk);
    check_model();
    chk("reset_valid", 16'(out_valid), 16'h0000);

    // Cold start: word == address, one instruction per cycle
    step(0, 0, 16'h0, 1);
    chk("cold_valid", 16'(out_valid), 16'h0001);
    chk("cold_pc0", out_pc, 16'h0000);
    for (int i = 1; i < 8; i++) begin
      step(0, 0, 16'h0, 1);
      chk("cold_seq", out_pc, 16'(i));
      chk("cold_instr", out_instr, out_pc);
    end

    // Backpressure
    step(1, 0, 16'h0, 0);
    step(1, 0, 16'h0, 0);
    repeat (10) step(0, 0, 16'h0, 0);
    chk("bp_occ", 16'(occupancy), 16'd4);
    chk("bp_addr", 16'(addr), 16'h0004);
    for (int i = 0; i < 6; i++) begin
      chk("bp_drain", out_pc, 16'(i));
      step(0, 0, 16'h0, 1);
    end

    // Redirect while full
    mode_id = 1'b0;
    repeat (2) step(0, 0, 16'h0, 0);
    chk("rd_full", 16'(occupancy), 16'd4);
    step(0, 1, 16'h0040, 0);
    chk("rd_occ0", 16'(occupancy), 16'd0);
    step(0, 0, 16'h0, 0);
    chk("rd_valid", 16'(out_valid), 16'h0001);
    chk("rd_target", out_pc, 16'h0040);

    // Redirect plus pop with a single entry
    step(0, 1, 16'h0100, 1);
    chk("rdpop_occ", 16'(occupancy), 16'd0);
    step(0, 0, 16'h0, 1);
    chk("rdpop_pc", out_pc, 16'h0100);

    // PC and address wrap
    step(0, 1, 16'hFFFE, 1);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 16'h0, 1);
      chk("wrap_pc", out_pc, wrap_pcs[i]);
    end

    // Reset beats a simultaneous redirect
    step(0, 1, 16'h0200, 0);
    repeat (3) step(0, 0, 16'h0, 0);
    chk("mid_occ3", 16'(occupancy), 16'd3);
    step(1, 1, 16'h0777, 1);
    chk("mid_occ0", 16'(occupancy), 16'd0);
    chk("mid_addr", 16'(addr), {4'h0, RESET_PC[11:0]});

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      bit          r, rd, rdy;
      logic [15:0] rpc;
      r   = ($urandom_range(49) == 0);
      rd  = ($urandom_range(15) == 0);
      rdy = ($urandom_range(3) != 0);
      rpc = 16'($urandom);
      if ($urandom_range(7) == 0) rpc = 16'hFFFD;
      step(r, rd, rpc, rdy);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
